// File: rtl/core_phase_sequencer_pkg.sv
// Shared definitions for the multi-cycle core phase sequencer.
//   CORE_XLEN : default datapath width (counter read ports are 2*CORE_XLEN wide)
//   phase_e   : 3-bit phase encoding, also used by debug/trace logic
package core_phase_sequencer_pkg;

  localparam int CORE_XLEN = 32;

  typedef enum logic [2:0] {
    PH_IDLE    = 3'd0,
    PH_FETCH   = 3'd1,
    PH_DECODE  = 3'd2,
    PH_EXECUTE = 3'd3,
    PH_MEMACC  = 3'd4,
    PH_WB      = 3'd5,
    PH_HALT    = 3'd6
  } phase_e;

endpackage

// File: rtl/core_phase_sequencer_watchdog.sv
// Stall watchdog for the phase sequencer.
// Counts consecutive stalled cycles in the current phase and raises a sticky
// error once the count reaches STALL_TIMEOUT. It never forces an advance.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   stalled      : current stage held this cycle
//   advance      : current stage moves on this cycle (clears the run)
//   timeout_err  : sticky, cleared only by rst_n
module core_phase_sequencer_watchdog #(
  parameter int STALL_TIMEOUT = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic stalled,
  input  logic advance,
  output logic timeout_err
);

  localparam logic [15:0] LIMIT = 16'(STALL_TIMEOUT);

  logic [15:0] stall_run_q, stall_run_d;
  logic        err_q, err_d;

  always_comb begin
    stall_run_d = stall_run_q;
    if (advance) begin
      stall_run_d = 16'd0;
    end else if (stalled && (stall_run_q != LIMIT)) begin
      // Saturate at the limit so a stuck stage cannot wrap the counter.
      stall_run_d = stall_run_q + 16'd1;
    end
    err_d = err_q | (stall_run_d == LIMIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_run_q <= 16'd0;
      err_q       <= 1'b0;
    end else begin
      stall_run_q <= stall_run_d;
      err_q       <= err_d;
    end
  end

  assign timeout_err = err_q;

endmodule

// File: rtl/core_phase_sequencer.sv
// Core control FSM for the multi-cycle RV32 core.
// Walks one instruction through FETCH->DECODE->EXECUTE->MEMACC->WB, drives the
// one-hot phase strobes, honours per-stage stalls, halts at instruction
// boundaries and keeps cycle/instret counters.
// Ports:
//   clk, rst_n                    : clock, asynchronous active-low reset
//   run_en                        : leave IDLE (sampled only in IDLE)
//   halt_req                      : halt at next WB exit, resume when low
//   stall_fetch/decode/execute/memoryaccess : per-stage hold requests
//   phase_*                       : one-hot strobes decoded from registered state
//   halted                        : parked in HALT
//   cycle_cnt, instret_cnt        : 2*XLEN wrapping counters
//   timeout_err                   : sticky stall-timeout flag
// Valid/ready: each stage's stall_* acts as a "not ready" for the active phase
// only; the phase advances on the first posedge where its own stall is low.
module core_phase_sequencer
  import core_phase_sequencer_pkg::*;
#(
  parameter int XLEN          = CORE_XLEN,
  parameter int STALL_TIMEOUT = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run_en,
  input  logic              halt_req,
  input  logic              stall_fetch,
  input  logic              stall_decode,
  input  logic              stall_execute,
  input  logic              stall_memoryaccess,
  output logic              phase_fetch,
  output logic              phase_decode,
  output logic              phase_execute,
  output logic              phase_memoryaccess,
  output logic              phase_writeback,
  output logic              halted,
  output logic [2*XLEN-1:0] cycle_cnt,
  output logic [2*XLEN-1:0] instret_cnt,
  output logic              timeout_err
);

  localparam int CW = 2 * XLEN;

  phase_e          state_q, state_d;
  logic            stalled, advance, in_stage;
  logic [CW-1:0]   cycle_cnt_q, cycle_cnt_d;
  logic [CW-1:0]   instret_cnt_q, instret_cnt_d;

  always_comb begin
    state_d  = state_q;
    stalled  = 1'b0;
    advance  = 1'b0;
    in_stage = 1'b1;
    case (state_q)
      PH_IDLE: begin
        in_stage = 1'b0;
        if (run_en) state_d = PH_FETCH;
      end
      PH_FETCH: begin
        if (stall_fetch) stalled = 1'b1;
        else begin state_d = PH_DECODE; advance = 1'b1; end
      end
      PH_DECODE: begin
        if (stall_decode) stalled = 1'b1;
        else begin state_d = PH_EXECUTE; advance = 1'b1; end
      end
      PH_EXECUTE: begin
        if (stall_execute) stalled = 1'b1;
        else begin state_d = PH_MEMACC; advance = 1'b1; end
      end
      PH_MEMACC: begin
        if (stall_memoryaccess) stalled = 1'b1;
        else begin state_d = PH_WB; advance = 1'b1; end
      end
      PH_WB: begin
        // halt_req is only looked at here, so an instruction always completes.
        advance = 1'b1;
        state_d = halt_req ? PH_HALT : PH_FETCH;
      end
      PH_HALT: begin
        in_stage = 1'b0;
        if (!halt_req) state_d = PH_FETCH;
      end
      default: begin
        in_stage = 1'b0;
        state_d  = PH_IDLE;
      end
    endcase

    cycle_cnt_d   = cycle_cnt_q + {{(CW-1){1'b0}}, in_stage};
    instret_cnt_d = instret_cnt_q + {{(CW-1){1'b0}}, (state_q == PH_WB)};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= PH_IDLE;
      cycle_cnt_q   <= '0;
      instret_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      cycle_cnt_q   <= cycle_cnt_d;
      instret_cnt_q <= instret_cnt_d;
    end
  end

  core_phase_sequencer_watchdog #(
    .STALL_TIMEOUT(STALL_TIMEOUT)
  ) u_watchdog (
    .clk         (clk),
    .rst_n       (rst_n),
    .stalled     (stalled),
    .advance     (advance),
    .timeout_err (timeout_err)
  );

  // Strobes come straight from the state register, so reset clears them at once.
  assign phase_fetch        = (state_q == PH_FETCH);
  assign phase_decode       = (state_q == PH_DECODE);
  assign phase_execute      = (state_q == PH_EXECUTE);
  assign phase_memoryaccess = (state_q == PH_MEMACC);
  assign phase_writeback    = (state_q == PH_WB);
  assign halted             = (state_q == PH_HALT);
  assign cycle_cnt          = cycle_cnt_q;
  assign instret_cnt        = instret_cnt_q;

endmodule

// File: tb/tb_core_phase_sequencer.sv
module tb_core_phase_sequencer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, run_en, halt_req;
  logic        stall_fetch, stall_decode, stall_execute, stall_memoryaccess;
  logic        phase_fetch, phase_decode, phase_execute, phase_memoryaccess, phase_writeback;
  logic        halted, timeout_err;
  logic [63:0] cycle_cnt, instret_cnt;

  // Narrow instance (XLEN=2 -> 4-bit counters) used to reach counter wrap quickly.
  logic        w_rst_n, w_run_en, w_zero;
  logic        w_pf, w_pd, w_pe, w_pm, w_pw, w_halted, w_timeout;
  logic [3:0]  w_cycle, w_instret;

  int checks = 0;
  int errors = 0;

  core_phase_sequencer #(.XLEN(32), .STALL_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .run_en(run_en), .halt_req(halt_req),
    .stall_fetch(stall_fetch), .stall_decode(stall_decode),
    .stall_execute(stall_execute), .stall_memoryaccess(stall_memoryaccess),
    .phase_fetch(phase_fetch), .phase_decode(phase_decode),
    .phase_execute(phase_execute), .phase_memoryaccess(phase_memoryaccess),
    .phase_writeback(phase_writeback), .halted(halted),
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt), .timeout_err(timeout_err)
  );

  core_phase_sequencer #(.XLEN(2), .STALL_TIMEOUT(4)) dut_w (
    .clk(clk), .rst_n(w_rst_n), .run_en(w_run_en), .halt_req(w_zero),
    .stall_fetch(w_zero), .stall_decode(w_zero),
    .stall_execute(w_zero), .stall_memoryaccess(w_zero),
    .phase_fetch(w_pf), .phase_decode(w_pd),
    .phase_execute(w_pe), .phase_memoryaccess(w_pm),
    .phase_writeback(w_pw), .halted(w_halted),
    .cycle_cnt(w_cycle), .instret_cnt(w_instret), .timeout_err(w_timeout)
  );

  // ---------------- driver / check tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // exp = {F,D,E,M,W}
  task automatic chk_ph(input string tag, input logic [4:0] exp, input logic exp_halted);
    chk({tag, "_phase"}, {59'd0, phase_fetch, phase_decode, phase_execute,
                          phase_memoryaccess, phase_writeback}, {59'd0, exp});
    chk({tag, "_halted"}, {63'd0, halted}, {63'd0, exp_halted});
  endtask

  localparam logic [4:0] P_NONE = 5'b00000;
  localparam logic [4:0] P_F    = 5'b10000;
  localparam logic [4:0] P_D    = 5'b01000;
  localparam logic [4:0] P_E    = 5'b00100;
  localparam logic [4:0] P_M    = 5'b00010;
  localparam logic [4:0] P_W    = 5'b00001;

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b0; run_en = 1'b0; halt_req = 1'b0;
    stall_fetch = 1'b0; stall_decode = 1'b0; stall_execute = 1'b0; stall_memoryaccess = 1'b0;
    w_rst_n = 1'b0; w_run_en = 1'b0; w_zero = 1'b0;
    #1;
    chk_ph("rst", P_NONE, 1'b0);
    chk("rst_cycle", cycle_cnt, 64'd0);
    chk("rst_instret", instret_cnt, 64'd0);
    chk("rst_timeout", {63'd0, timeout_err}, 64'd0);

    // 1: reset for 2 clocks, then run_en at the first edge after release
    step(); step();
    rst_n = 1'b1; run_en = 1'b1;
    step(); chk_ph("t1_f", P_F, 1'b0);
    run_en = 1'b0;
    step(); chk_ph("t1_d", P_D, 1'b0);
    step(); chk_ph("t1_e", P_E, 1'b0);
    step(); chk_ph("t1_m", P_M, 1'b0);
    step(); chk_ph("t1_w", P_W, 1'b0);
    chk("t1_instret_in_wb", instret_cnt, 64'd0);
    step(); chk_ph("t1_f2", P_F, 1'b0);
    chk("t1_instret", instret_cnt, 64'd1);
    chk("t1_cycle", cycle_cnt, 64'd5);

    // 2: execute stalls 3 cycles; decode stall during EXECUTE is ignored
    step(); chk_ph("t2_d", P_D, 1'b0);
    stall_execute = 1'b1;
    step(); chk_ph("t2_e0", P_E, 1'b0);
    stall_decode = 1'b1;
    step(); chk_ph("t2_e1", P_E, 1'b0);
    step(); chk_ph("t2_e2", P_E, 1'b0);
    step(); chk_ph("t2_e3", P_E, 1'b0);
    stall_execute = 1'b0;
    step(); chk_ph("t2_m", P_M, 1'b0);
    stall_decode = 1'b0;
    step(); chk_ph("t2_w", P_W, 1'b0);
    step(); chk_ph("t2_f", P_F, 1'b0);
    chk("t2_cycle", cycle_cnt, 64'd13);      // 5 + 8
    chk("t2_instret", instret_cnt, 64'd2);
    chk("t2_timeout", {63'd0, timeout_err}, 64'd0);

    // 3: halt requested during DECODE, instruction still completes
    step(); chk_ph("t3_d", P_D, 1'b0);
    halt_req = 1'b1;
    step(); chk_ph("t3_e", P_E, 1'b0);
    step(); chk_ph("t3_m", P_M, 1'b0);
    step(); chk_ph("t3_w", P_W, 1'b0);
    step(); chk_ph("t3_halt", P_NONE, 1'b1);
    chk("t3_instret", instret_cnt, 64'd3);
    chk("t3_cycle_h0", cycle_cnt, 64'd18);
    for (int i = 0; i < 9; i++) step();
    chk_ph("t3_halt9", P_NONE, 1'b1);
    chk("t3_cycle_h9", cycle_cnt, 64'd18);
    halt_req = 1'b0;
    step(); chk_ph("t3_resume", P_F, 1'b0);
    chk("t3_cycle_resume", cycle_cnt, 64'd18);

    // 4: asynchronous reset in MEMACC
    step(); step(); step(); chk_ph("t4_m", P_M, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk_ph("t4_async", P_NONE, 1'b0);
    chk("t4_instret", instret_cnt, 64'd0);
    chk("t4_cycle", cycle_cnt, 64'd0);
    step(); chk_ph("t4_hold", P_NONE, 1'b0);
    chk("t4_instret_hold", instret_cnt, 64'd0);
    rst_n = 1'b1;
    step(); chk_ph("t4_idle", P_NONE, 1'b0);   // run_en low: stays IDLE
    run_en = 1'b1;
    step(); chk_ph("t4_f", P_F, 1'b0);
    run_en = 1'b0;

    // 5: watchdog with STALL_TIMEOUT=4
    step(); step();
    stall_memoryaccess = 1'b1;
    step(); chk_ph("t5_m", P_M, 1'b0);
    chk("t5_to_0", {63'd0, timeout_err}, 64'd0);
    step(); step(); step();
    chk_ph("t5_m3", P_M, 1'b0);
    chk("t5_to_3", {63'd0, timeout_err}, 64'd0);
    step();
    chk("t5_to_4", {63'd0, timeout_err}, 64'd1);
    chk_ph("t5_m4", P_M, 1'b0);
    stall_memoryaccess = 1'b0;
    step(); chk_ph("t5_w", P_W, 1'b0);
    step(); chk_ph("t5_f", P_F, 1'b0);
    chk("t5_instret", instret_cnt, 64'd1);
    chk("t5_to_sticky", {63'd0, timeout_err}, 64'd1);

    // 6: counter wrap on the 4-bit instance
    w_rst_n = 1'b1; w_run_en = 1'b1;
    step();
    chk("t6_wf", {63'd0, w_pf}, 64'd1);
    w_run_en = 1'b0;
    for (int i = 0; i < 75; i++) step();
    chk("t6_instret15", {60'd0, w_instret}, 64'd15);
    chk("t6_cycle75", {60'd0, w_cycle}, 64'd11);  // 75 mod 16
    for (int i = 0; i < 5; i++) step();
    chk("t6_instret_wrap", {60'd0, w_instret}, 64'd0);
    chk("t6_cycle_wrap", {60'd0, w_cycle}, 64'd0);  // 80 mod 16
    chk("t6_wf2", {63'd0, w_pf}, 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
